// File: rtl/apb_pkg.sv
// apb_pkg: shared state encoding and default bus widths for the APB master arbiter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam int APB_ADDR_W = 3;
    localparam int APB_DATA_W = 5;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request after last, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    input  logic                    en,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] id
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0] hi;
    logic [NREQ-1:0] req_hi;
    logic [NREQ-1:0] pick;

    for (genvar g = 0; g < NREQ; g++) begin : g_hi
        assign hi[g] = ID_W'(g) > last;
    end

    // Requests above the pointer take priority; otherwise wrap to the lowest set bit.
    assign req_hi = req & hi;
    assign pick   = |req_hi ? req_hi & (~req_hi + 1'b1) : req & (~req + 1'b1);
    assign grant  = en ? pick : '0;

    for (genvar b = 0; b < ID_W; b++) begin : g_enc
        logic [NREQ-1:0] m;
        for (genvar g = 0; g < NREQ; g++) begin : g_m
            assign m[g] = 1'((g >> b) & 1);
        end
        assign id[b] = |(grant & m);
    end

endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb: APB master sharing one slave between NREQ requesters, round-robin,
// with optional ACCESS timeout and a registered response port.
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [ADDR_W-1:0]        padd,
    output logic [DATA_W-1:0]        pwdata,
    input  logic [DATA_W-1:0]        prdata,
    input  logic                     pready
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [NREQ-1:0]     arb_grant;
    logic [ID_W-1:0]     arb_id;
    logic [ADDR_W-1:0]   addr_a  [NREQ];
    logic [DATA_W-1:0]   wdata_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req),
        .last  (last_q),
        .en    (state_q == IDLE),
        .grant (arb_grant),
        .id    (arb_id)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            IDLE: if (|req) begin
                state_d = SETUP;
                id_d    = arb_id;
                last_d  = arb_id;
                write_d = req_write[arb_id];
                addr_d  = addr_a[arb_id];
                wdata_d = wdata_a[arb_id];
                cnt_d   = '0;
                gnt_d   = arb_grant;
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
                if (pready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = write_q ? '0 : prdata;
                end else if (TIMEOUT_CYC != 0 && cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        psel_d    = state_d != IDLE;
        penable_d = state_d == ACCESS;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            last_q      <= ID_W'(NREQ - 1);
            id_q        <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // The command latch doubles as the APB field drivers; id stays put until the next grant.
    assign gnt       = gnt_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = write_q;
    assign padd      = addr_q;
    assign pwdata    = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: directed tests against a transaction-level reference model of the arbiter.
module tb_apb_master_arb;
    localparam int NREQ = 2;
    localparam int AW   = 3;
    localparam int DW   = 5;
    localparam int TO   = 4;

    logic            clk = 1'b0;
    logic            preset = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] req_write = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0] gnt;
    logic            rsp_valid;
    logic [0:0]      rsp_id;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            psel, penable, pwrite;
    logic [AW-1:0]   padd;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata = '0;
    logic            pready = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int slv_wait = 0;
    bit spur = 1'b0;
    logic [DW-1:0] slv_data = '0;
    int acc_n = 0;

    int glog_id[$];
    int glog_cyc[$];
    int gi;

    // Reference model: a transfer record plus the age of the transfer in cycles.
    bit m_busy = 1'b0;
    int m_age = 0, m_id = 0, m_last = NREQ - 1, mi;
    bit m_w = 1'b0;
    int m_a = 0, m_d = 0;
    int e_gnt = 0, e_id = 0, e_rd = 0;
    bit e_rv = 1'b0, e_err = 1'b0;

    apb_master_arb #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .pclk      (clk),
        .preset    (preset),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .padd      (padd),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        e_gnt = 0;
        e_rv  = 1'b0;
        e_err = 1'b0;
        e_rd  = 0;
        if (preset) begin
            m_busy = 1'b0;
            m_last = NREQ - 1;
        end else if (!m_busy) begin
            for (int k = 1; k <= NREQ; k++) begin
                mi = (m_last + k) % NREQ;
                if (!m_busy && req[mi]) begin
                    m_busy = 1'b1;
                    m_age  = 0;
                    m_id   = mi;
                    m_last = mi;
                    m_w    = req_write[mi];
                    m_a    = int'(req_addr[mi*AW +: AW]);
                    m_d    = int'(req_wdata[mi*DW +: DW]);
                    e_gnt  = 1 << mi;
                end
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (pready) begin
            m_busy = 1'b0;
            e_rv   = 1'b1;
            e_id   = m_id;
            e_rd   = m_w ? 0 : int'(prdata);
        end else if (TO != 0 && m_age == TO) begin
            m_busy = 1'b0;
            e_rv   = 1'b1;
            e_err  = 1'b1;
            e_id   = m_id;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        check("gnt", gnt, e_gnt);
        check("psel", psel, m_busy);
        check("penable", penable, m_busy && m_age >= 1);
        check("rsp_valid", rsp_valid, e_rv);
        if (m_busy) begin
            check("pwrite", pwrite, m_w);
            check("padd", padd, m_a);
            check("pwdata", pwdata, m_d);
        end
        if (e_rv) begin
            check("rsp_id", rsp_id, e_id);
            check("rsp_rdata", rsp_rdata, e_rd);
            check("rsp_err", rsp_err, e_err);
        end
    end

    always @(negedge clk) begin
        if (gnt != '0) begin
            gi = 0;
            for (int i = 0; i < NREQ; i++) if (gnt[i]) gi = i;
            glog_id.push_back(gi);
            glog_cyc.push_back(cyc);
        end
    end

    // Reactive slave: pready after slv_wait ACCESS cycles (never if negative), or forced by spur.
    always @(posedge clk) begin
        #1;
        if (psel === 1'b1 && penable === 1'b1) begin
            pready = (slv_wait >= 0 && acc_n == slv_wait) || spur;
            acc_n++;
        end else begin
            acc_n  = 0;
            pready = spur;
        end
        prdata = slv_data;
    end

    task automatic set_cmd(input int id, input bit w, input int a, input int d);
        req_write[id] = w;
        req_addr[id*AW +: AW] = AW'(a);
        req_wdata[id*DW +: DW] = DW'(d);
    endtask

    task automatic wait_gnt(input int id);
        int n = 0;
        do begin @(negedge clk); n++; end while (gnt[id] !== 1'b1 && n < 20);
        check("gnt_seen", gnt[id], 1);
    endtask

    task automatic wait_rsp();
        int n = 0;
        do begin @(negedge clk); n++; end while (rsp_valid !== 1'b1 && n < 30);
        check("rsp_seen", rsp_valid, 1);
    endtask

    task automatic drop(input int id);
        @(posedge clk); #2;
        req[id] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, acc, rv_seen;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_psel", psel, 0);
        check("reset_gnt", gnt, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        @(posedge clk); #2;
        preset = 1'b0;

        // Single write, slave ready in the first ACCESS cycle.
        set_cmd(0, 1'b1, 3, 5'h15);
        slv_wait = 0;
        req[0] = 1'b1;
        wait_gnt(0);
        check("wr_setup_psel", psel, 1);
        check("wr_setup_penable", penable, 0);
        check("wr_setup_pwrite", pwrite, 1);
        check("wr_setup_padd", padd, 3);
        check("wr_setup_pwdata", pwdata, 5'h15);
        drop(0);
        @(negedge clk);
        check("wr_access_penable", penable, 1);
        wait_rsp();
        check("wr_rsp_id", rsp_id, 0);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);

        // Read with wait states from requester 1.
        set_cmd(1, 1'b0, 3, 0);
        slv_data = 5'h15;
        slv_wait = 2;
        req[1] = 1'b1;
        wait_gnt(1);
        drop(1);
        wait_rsp();
        check("rd_rsp_rdata", rsp_rdata, 5'h15);
        check("rd_rsp_id", rsp_id, 1);

        // Contention: both requesters held for four transfers.
        set_cmd(0, 1'b1, 1, 5'h0a);
        set_cmd(1, 1'b1, 2, 5'h0b);
        slv_wait = 0;
        glog_id.delete();
        glog_cyc.delete();
        req = 2'b11;
        n = 0;
        while (glog_id.size() < 4 && n < 40) begin @(negedge clk); #1; n++; end
        @(posedge clk); #2;
        req = 2'b00;
        check("cont_grants", glog_id.size(), 4);
        for (int k = 0; k < glog_id.size() && k < 4; k++) begin
            check("cont_order", glog_id[k], k % 2);
            if (k > 0) check("cont_gap", glog_cyc[k] - glog_cyc[k-1], 3);
        end
        wait_rsp();

        // Timeout: slave never ready.
        set_cmd(0, 1'b0, 5, 0);
        slv_wait = -1;
        req[0] = 1'b1;
        wait_gnt(0);
        drop(0);
        n = 0;
        acc = 0;
        do begin
            @(negedge clk);
            if (psel === 1'b1 && penable === 1'b1) acc++;
            n++;
        end while (rsp_valid !== 1'b1 && n < 30);
        check("to_rsp_seen", rsp_valid, 1);
        check("to_access_cycles", acc, TO);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        @(negedge clk);
        check("to_bus_idle", psel, 0);
        slv_wait = 0;
        set_cmd(1, 1'b1, 6, 5'h1f);
        req[1] = 1'b1;
        wait_gnt(1);
        drop(1);
        wait_rsp();
        check("after_to_err", rsp_err, 0);
        check("after_to_id", rsp_id, 1);

        // Reset while in ACCESS aborts the transfer and rewinds the pointer.
        set_cmd(0, 1'b1, 2, 7);
        slv_wait = -1;
        req[0] = 1'b1;
        wait_gnt(0);
        drop(0);
        preset = 1'b1;
        @(posedge clk); #2;
        preset = 1'b0;
        rv_seen = 0;
        @(negedge clk);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        rv_seen += int'(rsp_valid);
        @(negedge clk);
        rv_seen += int'(rsp_valid);
        check("rst_no_rsp", rv_seen, 0);
        slv_wait = 0;
        set_cmd(0, 1'b0, 1, 0);
        set_cmd(1, 1'b0, 2, 0);
        slv_data = 5'h09;
        glog_id.delete();
        glog_cyc.delete();
        req = 2'b11;
        wait_gnt(0);
        #1;
        check("rst_first_grant", glog_id.size() > 0 ? glog_id[0] : -1, 0);
        drop(0);
        wait_gnt(1);
        drop(1);
        wait_rsp();
        check("rst_second_id", rsp_id, 1);

        // Spurious pready outside ACCESS.
        spur = 1'b1;
        rv_seen = 0;
        repeat (4) begin @(negedge clk); rv_seen += int'(rsp_valid); end
        check("spur_idle_no_rsp", rv_seen, 0);
        set_cmd(1, 1'b0, 4, 0);
        slv_data = 5'h0c;
        req[1] = 1'b1;
        wait_gnt(1);
        check("spur_setup_penable", penable, 0);
        drop(1);
        @(negedge clk);
        check("spur_access_psel", psel, 1);
        check("spur_access_penable", penable, 1);
        wait_rsp();
        check("spur_rsp_rdata", rsp_rdata, 5'h0c);
        spur = 1'b0;

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
